q_pulse_serializer: RTL and testbench

Synthesizable transmitter for the serialized-charge pulse protocol. It converts a charge value into a train of fixed-width pulses on q_serialized, one pulse per Q_PER_PULSE units of charge. After the last pulse it holds the line low for an end-of-frame gap, which the receiver's Q-measurement watchdog uses to close the frame. It is the driving end for the Q-measurement deserializer in top and replaces the behavioural resonant system emulation in synthesizable test and bring-up builds.

---
 rtl/q_pulse_serializer.sv | 117 +++++++++++
 tb/tb_q_pulse_serializer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/q_pulse_serializer.sv
// Serialized-charge pulse transmitter: emits one fixed-width pulse per Q_PER_PULSE units
// of captured charge, then a low end-of-frame gap followed by a one-cycle frame_done strobe.
module q_pulse_serializer #(
    parameter int BUS_WIDTH      = 10,
    parameter int Q_PER_PULSE    = 10,
    parameter int PULSE_DURATION = 3,
    parameter int GAP_DURATION   = 2,
    parameter int FRAME_GAP      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [BUS_WIDTH-1:0] q_value,
    output logic                 q_serialized,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CNT_MAX_PG = (PULSE_DURATION > GAP_DURATION) ? PULSE_DURATION : GAP_DURATION;
    localparam int CNT_MAX    = (CNT_MAX_PG > FRAME_GAP) ? CNT_MAX_PG : FRAME_GAP;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_HIGH      = 2'd1;
    localparam logic [1:0] S_GAP       = 2'd2;
    localparam logic [1:0] S_FRAME_END = 2'd3;

    localparam logic [BUS_WIDTH-1:0] QUANTUM    = BUS_WIDTH'(Q_PER_PULSE);
    localparam logic [CNT_W-1:0]     PULSE_LAST = CNT_W'(PULSE_DURATION - 1);
    localparam logic [CNT_W-1:0]     GAP_LAST   = CNT_W'(GAP_DURATION - 1);
    localparam logic [CNT_W-1:0]     FGAP_LAST  = CNT_W'(FRAME_GAP - 1);

    logic [1:0]           state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BUS_WIDTH-1:0] remaining, remaining_n;
    logic                 done_n;

    // Only called after a >= QUANTUM check, so the result never wraps.
    function automatic logic [BUS_WIDTH-1:0] take_quantum(input logic [BUS_WIDTH-1:0] charge);
        return charge - QUANTUM;
    endfunction

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        remaining_n = remaining;
        done_n      = 1'b0;
        case (state)
            S_IDLE: begin
                if (load) begin
                    if (q_value >= QUANTUM) begin
                        state_n     = S_HIGH;
                        cnt_n       = PULSE_LAST;
                        remaining_n = take_quantum(q_value);
                    end else begin
                        state_n     = S_FRAME_END;
                        cnt_n       = FGAP_LAST;
                        remaining_n = q_value;
                    end
                end
            end
            S_HIGH: begin
                if (cnt == '0) begin
                    if (remaining >= QUANTUM) begin
                        state_n = S_GAP;
                        cnt_n   = GAP_LAST;
                    end else begin
                        state_n = S_FRAME_END;
                        cnt_n   = FGAP_LAST;
                    end
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_n     = S_HIGH;
                    cnt_n       = PULSE_LAST;
                    remaining_n = take_quantum(remaining);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                // Residual charge is dropped here so it never leaks into the next frame.
                if (cnt == '0) begin
                    state_n     = S_IDLE;
                    cnt_n       = '0;
                    remaining_n = '0;
                    done_n      = 1'b1;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
        endcase
    end

    // Outputs are registered from the next state, so the line follows the FSM with no input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            remaining    <= '0;
            q_serialized <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            remaining    <= remaining_n;
            q_serialized <= (state_n == S_HIGH);
            busy         <= (state_n != S_IDLE);
            frame_done   <= done_n;
        end
    end

endmodule

// File: tb/tb_q_pulse_serializer.sv
// Directed bench for q_pulse_serializer: frame timing, boundary charges, handshake and reset abort.
module tb_q_pulse_serializer;

    localparam int PULSE = 3;
    localparam int GAP   = 2;
    localparam int FGAP  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [9:0] q_value = '0;
    logic       q_serialized, busy, frame_done;

    int checks   = 0;
    int failures = 0;

    q_pulse_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .q_value     (q_value),
        .q_serialized(q_serialized),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Called at the negedge where load is already driven; returns at the frame_done (first IDLE) sample.
    task automatic monitor_frame(input string name, input bit hold, input int exp_n, input int exp_busy);
        int cycles = 0;
        int pulses = 0;
        int run    = 0;
        int badw   = 0;
        int fd_mid = 0;
        bit prev   = 1'b0;
        @(negedge clk);
        if (!hold) load = 1'b0;
        checks++;
        if (busy !== 1'b1 || q_serialized !== (exp_n > 0)) begin
            failures++;
            $display("FAIL %s_latency busy=%b q=%b required busy=1 q=%b", name, busy, q_serialized, exp_n > 0);
        end
        while (busy === 1'b1 && cycles < 3000) begin
            cycles++;
            if (frame_done !== 1'b0) fd_mid++;
            if (q_serialized) begin
                if (!prev) begin
                    if (pulses > 0 && run != GAP) badw++;
                    pulses++;
                    run = 0;
                end
                run++;
            end else begin
                if (prev) begin
                    if (run != PULSE) badw++;
                    run = 0;
                end
                run++;
            end
            prev = q_serialized;
            @(negedge clk);
        end
        if (hold) load = 1'b0;
        checks++;
        if (cycles !== exp_busy) begin
            failures++;
            $display("FAIL %s_busy_cycles got=%0d required=%0d", name, cycles, exp_busy);
        end
        checks++;
        if (pulses !== exp_n) begin
            failures++;
            $display("FAIL %s_pulses got=%0d required=%0d", name, pulses, exp_n);
        end
        checks++;
        if (badw !== 0 || run !== FGAP) begin
            failures++;
            $display("FAIL %s_widths bad=%0d trailing_low=%0d required bad=0 trailing_low=%0d", name, badw, run, FGAP);
        end
        checks++;
        if (frame_done !== 1'b1 || fd_mid !== 0) begin
            failures++;
            $display("FAIL %s_frame_done end=%b early=%0d required end=1 early=0", name, frame_done, fd_mid);
        end
    endtask

    task automatic run_frame(input string name, input logic [9:0] q, input bit hold, input int exp_n, input int exp_busy);
        @(negedge clk);
        load = 1'b1;
        q_value = q;
        monitor_frame(name, hold, exp_n, exp_busy);
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_after fd=%b busy=%b required 0 0", name, frame_done, busy);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        load = 1'b1;
        q_value = 10'd301;
        repeat (5) begin
            @(negedge clk);
            if (q_serialized !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_outputs bad_cycles=%0d required=0", bad);
        end
        load = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || q_serialized !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_start busy=%b q=%b required 0 0", busy, q_serialized);
        end
    endtask

    task automatic test_nominal();
        run_frame("nominal301", 10'd301, 1'b0, 30, 30 * PULSE + 29 * GAP + FGAP);
    endtask

    task automatic test_sub_quantum();
        run_frame("sub9", 10'd9, 1'b0, 0, FGAP);
        run_frame("zero", 10'd0, 1'b0, 0, FGAP);
    endtask

    task automatic test_boundary();
        run_frame("exact10", 10'd10, 1'b0, 1, PULSE + FGAP);
        run_frame("max1023", 10'd1023, 1'b0, 102, 102 * PULSE + 101 * GAP + FGAP);
    endtask

    task automatic test_load_held();
        run_frame("held50", 10'd50, 1'b1, 5, 5 * PULSE + 4 * GAP + FGAP);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        load = 1'b1;
        q_value = 10'd30;
        monitor_frame("b2b_first", 1'b0, 3, 3 * PULSE + 2 * GAP + FGAP);
        load = 1'b1;
        q_value = 10'd20;
        monitor_frame("b2b_second", 1'b0, 2, 2 * PULSE + GAP + FGAP);
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_after fd=%b busy=%b required 0 0", frame_done, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fd_seen = 0;
        @(negedge clk);
        load = 1'b1;
        q_value = 10'd301;
        @(negedge clk);
        load = 1'b0;
        // Pulse 7 rises on busy cycle 31; sample cycle 32 is its second high cycle.
        repeat (31) @(negedge clk);
        checks++;
        if (q_serialized !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre q=%b busy=%b required 1 1", q_serialized, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (q_serialized !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async q=%b busy=%b fd=%b required 0 0 0", q_serialized, busy, frame_done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || busy !== 1'b0) fd_seen++;
        end
        checks++;
        if (fd_seen !== 0) begin
            failures++;
            $display("FAIL midrst_no_done bad_cycles=%0d required=0", fd_seen);
        end
        run_frame("post_rst30", 10'd30, 1'b0, 3, 3 * PULSE + 2 * GAP + FGAP);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_sub_quantum();
        test_boundary();
        test_load_held();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
